// File: rtl/pipe_stage_reg_if.sv
// Bundle of control, upstream and registered-output signals for one pipeline stage register.
// The master side is the upstream stage plus pipeline control; the slave side is the register.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 138,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              bubble;
    logic              clr_cnt;
    logic [3:0]        in_stat;
    logic [3:0]        in_icode;
    logic [DATA_W-1:0] in_data;
    logic [3:0]        out_stat;
    logic [3:0]        out_icode;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              frozen;
    logic              ctrl_err;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output stall, bubble, clr_cnt, in_stat, in_icode, in_data,
        input  out_stat, out_icode, out_data, out_valid, frozen, ctrl_err,
               stall_cnt, bubble_cnt
    );

    modport slave (
        input  stall, bubble, clr_cnt, in_stat, in_icode, in_data,
        output out_stat, out_icode, out_data, out_valid, frozen, ctrl_err,
               stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic Y86-64 pipeline stage register: stat/icode/payload with stall, bubble,
// sticky freeze on exception, conflicting-control flag and saturating event counters.
module pipe_stage_reg #(
    parameter int       DATA_W        = 138,
    parameter logic [3:0] BUB_STAT    = 4'h8,
    parameter logic [3:0] NOP_ICODE   = 4'h1,
    parameter bit       FREEZE_ON_EXC = 1'b1,
    parameter int       CNT_W         = 16
) (
    input logic              clk,
    input logic              rst_n,
    pipe_stage_reg_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]        stat_q,  stat_d;
    logic [3:0]        icode_q, icode_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              frozen_q, frozen_d;
    logic              ctrl_err_q, ctrl_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic do_bubble, do_stall, do_load, in_exc;

    always_comb begin
        do_bubble = !frozen_q && bus.bubble;
        do_stall  = !frozen_q && !bus.bubble && bus.stall;
        do_load   = !frozen_q && !bus.bubble && !bus.stall;
        in_exc    = (bus.in_stat == 4'd2) || (bus.in_stat == 4'd3) || (bus.in_stat == 4'd4);
    end

    always_comb begin
        stat_d  = stat_q;
        icode_d = icode_q;
        data_d  = data_q;
        if (do_bubble) begin
            stat_d  = BUB_STAT;
            icode_d = NOP_ICODE;
            data_d  = '0;
        end else if (do_load) begin
            stat_d  = bus.in_stat;
            icode_d = bus.in_icode;
            data_d  = bus.in_data;
        end
    end

    // The exception load itself completes; only subsequent edges are blocked.
    always_comb begin
        frozen_d   = frozen_q || (FREEZE_ON_EXC && do_load && in_exc);
        ctrl_err_d = ctrl_err_q || (bus.stall && bus.bubble);
    end

    // Clear takes precedence over a coincident increment.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.clr_cnt) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (do_stall && stall_cnt_q != CNT_MAX)
                stall_cnt_d = stall_cnt_q + 1'b1;
            if (do_bubble && bubble_cnt_q != CNT_MAX)
                bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q       <= BUB_STAT;
            icode_q      <= NOP_ICODE;
            data_q       <= '0;
            frozen_q     <= 1'b0;
            ctrl_err_q   <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stat_q       <= stat_d;
            icode_q      <= icode_d;
            data_q       <= data_d;
            frozen_q     <= frozen_d;
            ctrl_err_q   <= ctrl_err_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.out_stat   = stat_q;
    assign bus.out_icode  = icode_q;
    assign bus.out_data   = data_q;
    assign bus.out_valid  = (stat_q != BUB_STAT);
    assign bus.frozen     = frozen_q;
    assign bus.ctrl_err   = ctrl_err_q;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: u0 uses default parameters, u1 has FREEZE_ON_EXC=0 and CNT_W=4;
// both receive identical stimulus and are checked against hand-computed values.
module tb_pipe_stage_reg;
    localparam int DW = 138;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    pipe_stage_reg_if #(.DATA_W(DW), .CNT_W(16)) if0 ();
    pipe_stage_reg_if #(.DATA_W(DW), .CNT_W(4))  if1 ();

    pipe_stage_reg #(.DATA_W(DW), .FREEZE_ON_EXC(1'b1), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    pipe_stage_reg #(.DATA_W(DW), .FREEZE_ON_EXC(1'b0), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic bb, input logic clr,
                         input logic [3:0] s, input logic [3:0] ic, input logic [DW-1:0] d);
        if0.stall = st; if0.bubble = bb; if0.clr_cnt = clr;
        if0.in_stat = s; if0.in_icode = ic; if0.in_data = d;
        if1.stall = st; if1.bubble = bb; if1.clr_cnt = clr;
        if1.in_stat = s; if1.in_icode = ic; if1.in_data = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_img(input string tag, input logic [3:0] s, input logic [3:0] ic,
                           input logic [DW-1:0] d, input logic v);
        chk({tag, "_stat0"},  {252'd0, if0.out_stat},  {252'd0, s});
        chk({tag, "_icode0"}, {252'd0, if0.out_icode}, {252'd0, ic});
        chk({tag, "_data0"},  {118'd0, if0.out_data},  {118'd0, d});
        chk({tag, "_valid0"}, {255'd0, if0.out_valid}, {255'd0, v});
    endtask

    task automatic chk_img1(input string tag, input logic [3:0] s, input logic [3:0] ic,
                            input logic [DW-1:0] d, input logic v);
        chk({tag, "_stat1"},  {252'd0, if1.out_stat},  {252'd0, s});
        chk({tag, "_icode1"}, {252'd0, if1.out_icode}, {252'd0, ic});
        chk({tag, "_data1"},  {118'd0, if1.out_data},  {118'd0, d});
        chk({tag, "_valid1"}, {255'd0, if1.out_valid}, {255'd0, v});
    endtask

    task automatic chk_cnt(input string tag, input int sc0, input int bc0, input int sc1, input int bc1);
        chk({tag, "_stall_cnt0"},  {240'd0, if0.stall_cnt},  256'(sc0));
        chk({tag, "_bubble_cnt0"}, {240'd0, if0.bubble_cnt}, 256'(bc0));
        chk({tag, "_stall_cnt1"},  {252'd0, if1.stall_cnt},  256'(sc1));
        chk({tag, "_bubble_cnt1"}, {252'd0, if1.bubble_cnt}, 256'(bc1));
    endtask

    initial begin
        logic [DW-1:0] wide;
        wide = {10'h2A5, 64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FEDC_BA98};

        // Run un-reset for two edges, then assert reset between edges.
        drive(1'b0, 1'b0, 1'b0, 4'd1, 4'd6, 138'h77);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk_img("reset", 4'h8, 4'h1, '0, 1'b0);
        chk_img1("reset", 4'h8, 4'h1, '0, 1'b0);
        chk("reset_frozen0", {255'd0, if0.frozen}, 256'd0);
        chk("reset_ctrl_err0", {255'd0, if0.ctrl_err}, 256'd0);
        chk_cnt("reset", 0, 0, 0, 0);
        #1 rst_n = 1'b1;

        // Normal flow
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 1'b0, 1'b0, 4'd1, 4'd6, DW'(k));
            step();
            chk_img($sformatf("load%0d", k), 4'd1, 4'd6, DW'(k), 1'b1);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd1, 4'd7, wide);
        step();
        chk_img("wide", 4'd1, 4'd7, wide, 1'b1);
        chk_cnt("flow", 0, 0, 0, 0);

        // Stall then bubble
        drive(1'b0, 1'b0, 1'b0, 4'd1, 4'd6, 138'hAA);
        step();
        drive(1'b1, 1'b0, 1'b0, 4'd1, 4'd9, 138'h55);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_img($sformatf("stall%0d", k), 4'd1, 4'd6, 138'hAA, 1'b1);
        end
        drive(1'b0, 1'b1, 1'b0, 4'd1, 4'd9, 138'h55);
        for (int k = 0; k < 2; k++) begin
            step();
            chk_img($sformatf("bubble%0d", k), 4'h8, 4'h1, '0, 1'b0);
        end
        chk_cnt("stall_bubble", 3, 2, 3, 2);
        chk("no_conflict_yet", {255'd0, if0.ctrl_err}, 256'd0);

        // Conflict: bubble wins, ctrl_err sticks
        drive(1'b0, 1'b0, 1'b0, 4'd1, 4'd6, 138'h33);
        step();
        drive(1'b1, 1'b1, 1'b0, 4'd1, 4'd6, 138'h66);
        step();
        chk_img("conflict", 4'h8, 4'h1, '0, 1'b0);
        chk("conflict_err0", {255'd0, if0.ctrl_err}, 256'd1);
        chk_cnt("conflict", 3, 3, 3, 3);
        drive(1'b0, 1'b0, 1'b0, 4'd1, 4'd6, 138'h44);
        step();
        chk_img("after_conflict", 4'd1, 4'd6, 138'h44, 1'b1);
        chk("err_sticky0", {255'd0, if0.ctrl_err}, 256'd1);
        chk("err_sticky1", {255'd0, if1.ctrl_err}, 256'd1);

        // Clear, saturation, clear coinciding with stall
        drive(1'b0, 1'b0, 1'b1, 4'd1, 4'd6, 138'h44);
        step();
        chk_cnt("clr", 0, 0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 138'h99);
        for (int k = 0; k < 20; k++) step();
        chk_cnt("sat", 20, 0, 15, 0);
        chk_img("sat_hold", 4'd1, 4'd6, 138'h44, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 4'd1, 4'd2, 138'h99);
        step();
        chk_cnt("clr_vs_stall", 0, 0, 0, 0);

        // Freeze on exception (u0) versus no freeze (u1)
        drive(1'b0, 1'b0, 1'b0, 4'd3, 4'd5, 138'h1234);
        step();
        chk_img("exc", 4'd3, 4'd5, 138'h1234, 1'b1);
        chk_img1("exc", 4'd3, 4'd5, 138'h1234, 1'b1);
        chk("frozen0", {255'd0, if0.frozen}, 256'd1);
        chk("frozen1", {255'd0, if1.frozen}, 256'd0);
        drive(1'b0, 1'b0, 1'b0, 4'd1, 4'd6, 138'h999);
        step();
        chk_img("frz_load", 4'd3, 4'd5, 138'h1234, 1'b1);
        chk_img1("nofrz_load", 4'd1, 4'd6, 138'h999, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 4'd1, 4'd6, 138'h999);
        step();
        chk_img("frz_bubble", 4'd3, 4'd5, 138'h1234, 1'b1);
        chk_img1("nofrz_bubble", 4'h8, 4'h1, '0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd1, 4'd6, 138'h999);
        step();
        chk_img("frz_stall", 4'd3, 4'd5, 138'h1234, 1'b1);
        chk_cnt("frz", 0, 0, 1, 1);
        drive(1'b0, 1'b0, 1'b1, 4'd1, 4'd6, 138'h999);
        step();
        chk_cnt("frz_clr", 0, 0, 0, 0);
        chk("frozen_sticky0", {255'd0, if0.frozen}, 256'd1);

        // Reset releases freeze and conflict flag
        #2 rst_n = 1'b0;
        #1;
        chk("rst_frozen0", {255'd0, if0.frozen}, 256'd0);
        chk("rst_err0", {255'd0, if0.ctrl_err}, 256'd0);
        chk_img("rst2", 4'h8, 4'h1, '0, 1'b0);
        #1 rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'd1, 4'd6, 138'h5A);
        step();
        chk_img("post_rst_load", 4'd1, 4'd6, 138'h5A, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
